// File: rtl/bus6502_mem_bridge.sv
// bus6502_mem_bridge
//
// Bridges a 6502 core onto a request/acknowledge memory port. The bridge
// generates the CPU clock (cpu_phi) from the system clock and stretches the
// high phase until memory completes the access. Each CPU cycle walks
// LOW -> HIGH -> WAIT -> DONE -> LOW. The bridge also sequences the CPU reset
// and counts completed opcode fetches.
//
// Parameters
//   TIMEOUT       system cycles spent in WAIT before the access is abandoned (1..255)
//   RESET_CYCLES  CPU cycles cpu_res_n is held low after res (2..15)
//
// Ports
//   phi          in   system clock, rising edge
//   res          in   synchronous active-high reset
//   cpu_phi      out  generated CPU clock (phi0), registered
//   cpu_res_n    out  active-low reset to the CPU core
//   cpu_ab       in   CPU address bus
//   cpu_rw       in   CPU read (1) / write (0)
//   cpu_sync     in   CPU opcode-fetch indicator
//   cpu_dout     in   CPU write data
//   cpu_din      out  read data returned to the CPU
//   mem_req      out  memory request level, held until ack or timeout
//   mem_we       out  1 = write access
//   mem_addr     out  access address
//   mem_wdata    out  write data
//   mem_ack      in   one-cycle completion pulse
//   mem_rdata    in   read data, valid with mem_ack
//   bus_err      out  sticky timeout flag
//   instr_count  out  completed opcode-fetch CPU cycles (wraps)

module bus6502_mem_bridge #(
    parameter int TIMEOUT      = 255,
    parameter int RESET_CYCLES = 8
) (
    input  logic        phi,
    input  logic        res,
    output logic        cpu_phi,
    output logic        cpu_res_n,
    input  logic [15:0] cpu_ab,
    input  logic        cpu_rw,
    input  logic        cpu_sync,
    input  logic [7:0]  cpu_dout,
    output logic [7:0]  cpu_din,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic        bus_err,
    output logic [31:0] instr_count
);

    typedef enum logic [1:0] {
        ST_LOW,
        ST_HIGH,
        ST_WAIT,
        ST_DONE
    } state_t;

    // The wait counter is compared against TIMEOUT-1 while still in WAIT, so
    // the cycle in which it would step to TIMEOUT is the last WAIT cycle:
    // exactly TIMEOUT WAIT cycles are spent before giving up.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);
    localparam logic [3:0] RESET_LAST   = 4'(RESET_CYCLES - 1);

    state_t      state;
    logic        sync_q;
    logic [7:0]  wait_cnt;
    logic [3:0]  rst_cnt;

    // Single-process FSM. cpu_phi is written together with the next state so
    // it is a clean register output: 0 only while the FSM sits in LOW.
    // In WAIT an acknowledge is checked before the timeout so that an ack
    // arriving in the final allowed cycle completes normally.
    // The CPU reset counter advances once per DONE until RESET_CYCLES CPU
    // cycles have completed; the DONE that releases cpu_res_n does not count
    // an opcode fetch because it still sees cpu_res_n low.
    always_ff @(posedge phi) begin
        if (res) begin
            state       <= ST_LOW;
            cpu_phi     <= 1'b0;
            cpu_res_n   <= 1'b0;
            cpu_din     <= 8'h00;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= 16'h0000;
            mem_wdata   <= 8'h00;
            bus_err     <= 1'b0;
            instr_count <= 32'd0;
            sync_q      <= 1'b0;
            wait_cnt    <= 8'd0;
            rst_cnt     <= 4'd0;
        end else begin
            case (state)
                ST_LOW: begin
                    state   <= ST_HIGH;
                    cpu_phi <= 1'b1;
                end

                ST_HIGH: begin
                    mem_addr  <= cpu_ab;
                    mem_we    <= ~cpu_rw;
                    mem_wdata <= cpu_dout;
                    sync_q    <= cpu_sync;
                    mem_req   <= 1'b1;
                    wait_cnt  <= 8'd0;
                    state     <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (!mem_we) begin
                            cpu_din <= mem_rdata;
                        end
                        state <= ST_DONE;
                    end else if (wait_cnt == TIMEOUT_LAST) begin
                        mem_req  <= 1'b0;
                        bus_err  <= 1'b1;
                        wait_cnt <= wait_cnt + 8'd1;
                        if (!mem_we) begin
                            cpu_din <= 8'hFF;
                        end
                        state <= ST_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end

                ST_DONE: begin
                    if (sync_q && cpu_res_n) begin
                        instr_count <= instr_count + 32'd1;
                    end
                    if (!cpu_res_n) begin
                        rst_cnt <= rst_cnt + 4'd1;
                        if (rst_cnt == RESET_LAST) begin
                            cpu_res_n <= 1'b1;
                        end
                    end
                    state   <= ST_LOW;
                    cpu_phi <= 1'b0;
                end

                default: begin
                    state   <= ST_LOW;
                    cpu_phi <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/bus6502_mem_bridge.md
BUS6502_MEM_BRIDGE -- requirements
Module: bus6502_mem_bridge

Interface
REQ-001 Parameter TIMEOUT, default 255: max system cycles waited for mem_ack per access (1..255).
REQ-002 Parameter RESET_CYCLES, default 8: CPU cycles cpu_res_n held low after reset (2..15).
REQ-003 phi  input  1  system clock; all state updates on rising edge.
REQ-004 res  input  1  reset; synchronous and active-high.
REQ-005 cpu_phi  output  1  generated CPU clock (phi0) to the 6502 core.
REQ-006 cpu_res_n  output  1  active-low reset to the 6502 core.
REQ-007 cpu_ab  input  16  CPU address bus.
REQ-008 cpu_rw  input  1  CPU read (1) / write (0).
REQ-009 cpu_sync  input  1  CPU opcode-fetch indicator.
REQ-010 cpu_dout  input  8  CPU write data (db when rw=0).
REQ-011 cpu_din  output  8  read data driven to CPU db.
REQ-012 mem_req  output  1  memory request, level, held until acknowledged.
REQ-013 mem_we  output  1  1 = write access.
REQ-014 mem_addr  output  16  access address.
REQ-015 mem_wdata  output  8  write data.
REQ-016 mem_ack  input  1  one-cycle completion pulse from memory.
REQ-017 mem_rdata  input  8  read data, valid in the mem_ack cycle.
REQ-018 bus_err  output  1  sticky timeout flag.
REQ-019 instr_count  output  32  completed opcode-fetch CPU cycles.

Function
REQ-020 FSM states: LOW, HIGH, WAIT, DONE; each CPU cycle visits LOW->HIGH->WAIT->DONE->LOW.
REQ-021 cpu_phi = 0 in LOW, 1 in HIGH/WAIT/DONE; registered output, no glitches.
REQ-022 LOW: 1 system cycle, then HIGH.
REQ-023 HIGH: 1 cycle; latches cpu_ab, cpu_rw, cpu_sync, cpu_dout into mem_addr, mem_we=~cpu_rw, mem_wdata, sync_q; sets mem_req=1; -> WAIT.
REQ-024 WAIT: mem_req, mem_addr, mem_we, mem_wdata stable; on mem_ack: mem_req=0 next cycle, reads capture mem_rdata into cpu_din, -> DONE.
REQ-025 mem_ack outside WAIT is ignored.
REQ-026 Timeout counter (8 bit) cleared in HIGH, increments each WAIT cycle without ack; counter==TIMEOUT with no ack -> mem_req=0, bus_err=1, cpu_din=8'hFF on read, -> DONE.
REQ-027 mem_ack in the same cycle the counter reaches TIMEOUT: ack wins, no error.
REQ-028 DONE: 1 cycle; if sync_q=1 and cpu_res_n=1, instr_count increments (wraps 2^32-1 -> 0); -> LOW.
REQ-029 Minimum CPU cycle = 4 system cycles (ack in first WAIT cycle); cpu_phi high time stretches with memory latency.
REQ-030 cpu_din holds value until next read completion; writes leave cpu_din unchanged.
REQ-031 Reset counter counts DONE states; cpu_res_n=0 until RESET_CYCLES CPU cycles completed, then 1 until next res.
REQ-032 Memory accesses are performed during cpu_res_n=0 as for any other cycle.

Reset
REQ-033 res=1 at a clock edge: state=LOW, cpu_phi=0, cpu_res_n=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_din=0, bus_err=0, instr_count=0, counters=0.
REQ-034 res mid-access (WAIT): mem_req drops next cycle; a subsequent mem_ack for the aborted access is ignored.
REQ-035 bus_err clears only on res.

Verification
REQ-036 Release res, mem_ack one cycle after every req, rdata=8'hEA -> cpu_phi period 4 cycles (0,1,1,1), cpu_res_n rises after 8 CPU cycles, cpu_din=8'hEA.
REQ-037 CPU drives ab=16'h0200, rw=0, dout=8'h5A -> mem_req=1, mem_we=1, mem_addr=16'h0200, mem_wdata=8'h5A held until ack; cpu_din unchanged.
REQ-038 Delay ack 10 cycles -> mem_req high exactly 10 WAIT cycles, cpu_phi high 12 cycles, no bus_err.
REQ-039 Never ack on read -> after TIMEOUT=255 WAIT cycles bus_err=1, cpu_din=8'hFF, FSM continues to LOW.
REQ-040 cpu_sync=1 for 3 of 5 cycles after cpu_res_n=1 -> instr_count=3; preload 32'hFFFFFFFF + one sync cycle -> 0.
REQ-041 Assert res in WAIT, then ack next cycle -> mem_req=0, state LOW, cpu_din=0, ack ignored.
